// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, flag bit positions, FSM encoding.
package alu_pkg;

  // ALU opcodes
  localparam logic [2:0] U_ADD  = 3'b000;
  localparam logic [2:0] S_ADD  = 3'b001;
  localparam logic [2:0] U_SUB  = 3'b010;
  localparam logic [2:0] S_SUB  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] DIV2   = 3'b111;

  // Bit positions inside the {carryout, overflow, zero} flag vector
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_Z = 0;

  // Driver FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  // A response counts as a flag event when carry/borrow or signed overflow was reported
  function automatic logic flag_event(input logic [2:0] flags);
    return flags[FLG_C] | flags[FLG_V];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over a same-cycle increment; increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_cmd_driver.sv
// Issues one command at a time to a registered ALU, waits out its latency and
// buffers the result/flags behind a valid/ready response port with statistics.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned NBITS   = 4,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [NBITS-1:0] cmd_a,
  input  logic [NBITS-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [NBITS-1:0] alu_a,
  output logic [NBITS-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [NBITS-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [NBITS-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [2:0]       rsp_op,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] flag_count
);

  localparam int unsigned WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ready_q, ready_d;
  logic [NBITS-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [NBITS-1:0]  res_q, res_d;
  logic [2:0]        flags_q, flags_d;
  logic [2:0]        rop_q, rop_d;
  logic              handshake;

  assign handshake = (state_q == RESP) && rsp_ready;

  // Next-state: accept in IDLE, count down ALU latency in DRIVE, hold response in RESP
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    rop_d   = rop_q;
    case (state_q)
      IDLE: begin
        // ready_q gates acceptance so the first cycle out of reset takes nothing
        if (ready_q && cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          op_d    = cmd_op;
          wait_d  = WAIT_W'(ALU_LAT);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          res_d   = alu_result;
          flags_d = {alu_carryout, alu_overflow, alu_zero};
          rop_d   = op_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so cmd_ready reads 0 in the cycle right after reset
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset abandons any command or pending response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      rop_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      rop_q   <= rop_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_op     = rop_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_op_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (handshake),
    .count (op_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flag_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (stat_clr),
    .inc   (handshake && flag_event(flags_q)),
    .count (flag_count)
  );

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench: two drivers (16-bit and 2-bit counters) share stimulus, each paired
// with a behavioural one-cycle registered 4-bit ALU.
module tb_alu_cmd_driver;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic       rsp_ready;
  logic       stat_clr;

  logic        cmd_ready, rsp_valid;
  logic [3:0]  alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  alu_opcode, rsp_flags, rsp_op;
  logic        alu_carryout, alu_overflow, alu_zero;
  logic [15:0] op_count, flag_count;

  logic       cmd_ready2, rsp_valid2;
  logic [3:0] alu_a2, alu_b2, alu_result2, rsp_result2;
  logic [2:0] alu_opcode2, rsp_flags2, rsp_op2;
  logic       alu_carryout2, alu_overflow2, alu_zero2;
  logic [1:0] op_count2, flag_count2;

  int total = 0;
  int bad   = 0;

  alu_cmd_driver #(.NBITS(4), .ALU_LAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_op(rsp_op),
    .stat_clr(stat_clr), .op_count(op_count), .flag_count(flag_count)
  );

  alu_cmd_driver #(.NBITS(4), .ALU_LAT(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_opcode(alu_opcode2),
    .alu_result(alu_result2), .alu_carryout(alu_carryout2), .alu_overflow(alu_overflow2),
    .alu_zero(alu_zero2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result2), .rsp_flags(rsp_flags2), .rsp_op(rsp_op2),
    .stat_clr(stat_clr), .op_count(op_count2), .flag_count(flag_count2)
  );

  // Behavioural ALU: returns {carry, overflow, zero, result}
  function automatic logic [6:0] alu_eval(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      3'b001: begin
        s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b010: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; end
      3'b011: begin
        s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: begin r = a >> 1; c = a[0]; end
    endcase
    return {c, v, (r == 4'h0), r};
  endfunction

  always @(posedge clk) begin
    {alu_carryout, alu_overflow, alu_zero, alu_result} <= alu_eval(alu_a, alu_b, alu_opcode);
    {alu_carryout2, alu_overflow2, alu_zero2, alu_result2} <=
      alu_eval(alu_a2, alu_b2, alu_opcode2);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op with rsp_ready high, starting at a negedge with the driver idle
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic [2:0] ef,
                        input int eo, input int efc, input logic clr);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_cmd_ready", cmd_ready, 0);
    check("accept_cmd_ready2", cmd_ready2, 0);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_opcode", alu_opcode, op);
    @(negedge clk);
    check("rsp_valid_early", rsp_valid, 0);
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_result", rsp_result, er);
    check("rsp_flags", rsp_flags, ef);
    check("rsp_op", rsp_op, op);
    check("rsp_valid2", rsp_valid2, 1);
    check("rsp_result2", rsp_result2, er);
    check("rsp_flags2", rsp_flags2, ef);
    check("rsp_op2", rsp_op2, op);
    stat_clr = clr;
    @(negedge clk);
    stat_clr = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
    check("op_count", op_count, eo);
    check("flag_count", flag_count, efc);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b0; stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_op_count", op_count, 0);
    check("rst_flag_count", flag_count, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    run_op(4'hF, 4'h1, 3'b000, 4'h0, 3'b101, 1, 1, 1'b0);  // uadd wrap
    run_op(4'h7, 4'h1, 3'b001, 4'h8, 3'b010, 2, 2, 1'b0);  // sadd overflow
    run_op(4'h3, 4'h3, 3'b011, 4'h0, 3'b001, 3, 2, 1'b0);  // ssub to zero

    // Backpressure: AND response held while a second command waits on cmd_valid
    cmd_a = 4'hC; cmd_b = 4'hA; cmd_op = 3'b100; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_a = 4'h5; cmd_b = 4'h3; cmd_op = 3'b110;
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_alu_a", alu_a, 4'hC);
    repeat (2) @(negedge clk);
    check("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_result", rsp_result, 4'h8);
      check("bp_hold_ready", cmd_ready, 0);
      check("bp_hold_alu_a", alu_a, 4'hC);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", rsp_valid, 0);
    check("bp_hs_ready", cmd_ready, 1);
    check("bp_hs_alu_a", alu_a, 4'hC);
    check("bp_hs_op_count", op_count, 4);
    check("sat2_early", op_count2, 3);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp2_cmd_ready", cmd_ready, 0);
    check("bp2_alu_a", alu_a, 4'h5);
    check("bp2_alu_opcode", alu_opcode, 3'b110);
    repeat (2) @(negedge clk);
    check("bp2_rsp_valid", rsp_valid, 1);
    check("bp2_rsp_result", rsp_result, 4'h6);
    check("bp2_rsp_flags", rsp_flags, 3'b000);
    @(negedge clk);
    check("bp2_op_count", op_count, 5);
    check("bp2_flag_count", flag_count, 2);

    // Reset pulse while in DRIVE
    cmd_a = 4'hF; cmd_b = 4'h1; cmd_op = 3'b000; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_opcode", alu_opcode, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_result", rsp_result, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_flag_count", flag_count, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid, 0);
    end
    check("mid_rst_op_count_after", op_count, 0);
    check("mid_rst_ready_after", cmd_ready, 1);

    // Saturation on the 2-bit counters
    for (int i = 1; i <= 5; i++) begin
      run_op(4'hF, 4'h1, 3'b000, 4'h0, 3'b101, i, i, 1'b0);
    end
    check("sat2_op_count", op_count2, 3);
    check("sat2_flag_count", flag_count2, 3);
    run_op(4'hF, 4'h1, 3'b000, 4'h0, 3'b101, 0, 0, 1'b1);  // clear on handshake edge
    check("clr2_op_count", op_count2, 0);
    check("clr2_flag_count", flag_count2, 0);

    // Shift right; opcode stays on the ALU port afterwards
    run_op(4'h8, 4'h0, 3'b111, 4'h4, 3'b000, 1, 0, 1'b0);
    check("div2_alu_opcode_idle", alu_opcode, 3'b111);
    check("div2_alu_a_idle", alu_a, 4'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
